dsram_arbiter: RTL and testbench
================================

# dsram_arbiter

Shares the single-port synchronous data SRAM between the CPU MEM stage and a DMA/debug requester. Grants one access per cycle, enforces CPU priority with a bounded DMA starvation limit, and routes one-cycle-latency read data back to the requester that issued the read. Sits between the MEM-stage byte-lane/extension logic and the `data_sram_*` pins of the CPU top.

## Interface
- `STARVE_MAX`, 4, number of consecutive denied DMA request cycles after which DMA wins the next arbitration (legal 1..15)
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  CPU access request
- `cpu_wr`  in  1  1 = store, 0 = load
- `cpu_wen`  in  4  byte-lane write enables (stores only)
- `cpu_addr`  in  32  byte address
- `cpu_wdata`  in  32  store data, already lane-aligned
- `cpu_gnt`  out  1  request accepted this cycle
- `cpu_rvalid`  out  1  load data valid
- `cpu_rdata`  out  32  load data (raw word; extension done downstream)
- `dma_req`, `dma_wr`, `dma_wen[3:0]`, `dma_addr[31:0]`, `dma_wdata[31:0]`  in  same meaning for DMA port
- `dma_gnt`, `dma_rvalid`, `dma_rdata[31:0]`  out  same meaning for DMA port
- `data_sram_en`  out  1  SRAM access enable
- `data_sram_wen`  out  4  SRAM byte write enables
- `data_sram_addr`  out  32  SRAM address, word-aligned
- `data_sram_wdata`  out  32  SRAM write data
- `data_sram_rdata`  in  32  SRAM read data, valid the cycle after a read enable

## Operation
- Transfer occurs in a cycle where `req && gnt`; at most one of `cpu_gnt`/`dma_gnt` high per cycle.
- `gnt` is combinational from current `req` and registered arbitration state; a requester holds `req` and all payload stable until it sees `gnt`.
- Arbitration: if only one requests, it is granted. If both request: DMA granted when `starve_cnt == STARVE_MAX`, otherwise CPU granted.
- `starve_cnt` (4 bits): increments (saturating at STARVE_MAX) each cycle `dma_req && !dma_gnt`; clears to 0 on any cycle DMA is granted or `dma_req` is low.
- SRAM drive on granted transfer: `data_sram_en=1`, `data_sram_addr={addr[31:2],2'b00}`, `data_sram_wdata=wdata`, `data_sram_wen = wr ? wen : 4'b0000`. No grant: `en=0`, `wen=0`, addr/wdata = 0.
- A store with `wen==0` is a legal no-op access; it consumes the grant, no rvalid.
- Read tracking: registers `rd_pend` (1) and `rd_owner` (0=CPU, 1=DMA) loaded on every granted read; cleared when no read granted.
- Return: cycle after a granted read, `rvalid` pulses 1 cycle on the owner's port; `rdata` of owner = `data_sram_rdata`; other port `rvalid=0`. `*_rdata` are 0 when `rvalid=0`.
- Back-to-back reads (either requester) are fully pipelined: one grant per cycle, returns in order.

## Timing
- Reset values: `cpu_gnt=dma_gnt=0` only while reset asserted; `cpu_rvalid=dma_rvalid=0`, `rdata=0`, `data_sram_en=0`, `data_sram_wen=0`, `starve_cnt=0`, `rd_pend=0`.
- Grant latency: 0 cycles (same cycle as `req` when uncontended).
- Read latency: `rvalid` exactly 1 cycle after grant cycle.
- Write latency: complete at the grant edge; no response.
- Reset mid-read: read granted in cycle N, reset high in N+1 → no `rvalid` in N+1 or later; pending read discarded.
- Reset and request same cycle: no grant, SRAM not enabled.
- Max DMA wait under continuous CPU traffic: STARVE_MAX cycles, granted on cycle STARVE_MAX+1.

## Test plan
- Single CPU load addr 0x1003, SRAM word 0xA5A5_1234 → cycle 0 `cpu_gnt=1`, `data_sram_addr=0x1000`, `wen=0`; cycle 1 `cpu_rvalid=1`, `cpu_rdata=0xA5A5_1234`, `dma_rvalid=0`.
- CPU store wen=4'b0011 data 0x0000_BEEF addr 0x20 → `data_sram_en=1`, `wen=0011`, `wdata=0x0000_BEEF`; next cycle no rvalid.
- Both request continuously (STARVE_MAX=4, all reads) → CPU granted cycles 0-3, DMA cycle 4, CPU cycle 5; `starve_cnt` 0,1,2,3,4,0; returns arrive on correct ports one cycle later each.
- Alternating CPU read / DMA read back-to-back → rvalid alternates ports every cycle with matching data, no bubbles.
- DMA read granted at cycle 5, reset asserted cycle 6 → `dma_rvalid=0` cycles 6-7, all outputs at reset values, `starve_cnt=0` after reset.
- DMA drops `req` after 3 denied cycles, re-requests → counter restarts at 0; needs 4 more denied cycles before priority flip.

Source files
------------

// File: rtl/dsram_arbiter.sv
// Arbitrates the single-port data SRAM between the CPU MEM stage and a DMA/debug port.
// CPU has priority; a DMA requester denied STARVE_MAX cycles in a row wins the next contest.

module dsram_arb_rsp #(
    parameter int unsigned PORT_ID = 0
) (
    input  logic        rd_pend,
    input  logic        rd_owner,
    input  logic        reset,
    input  logic [31:0] sram_rdata,
    output logic        rvalid,
    output logic [31:0] rdata
);
    localparam logic OWNER = 1'(PORT_ID);

    // A read in flight when reset arrives is dropped, not returned.
    assign rvalid = rd_pend && !reset && (rd_owner == OWNER);
    assign rdata  = rvalid ? sram_rdata : '0;
endmodule

module dsram_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [3:0]  dma_wen,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata
);
    localparam int unsigned NUM_PORTS  = 2;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dsram_req_t;

    dsram_req_t [NUM_PORTS-1:0]        port_req;
    dsram_req_t                        sel;
    logic [NUM_PORTS-1:0]              gnt;
    logic [NUM_PORTS-1:0]              rvalid;
    logic [NUM_PORTS-1:0][31:0]        rdata;
    logic [3:0]                        starve_cnt;
    logic                              rd_pend;
    logic                              rd_owner;
    logic                              any_gnt;
    logic                              rd_grant;

    assign port_req[0] = {cpu_req, cpu_wr, cpu_wen, cpu_addr, cpu_wdata};
    assign port_req[1] = {dma_req, dma_wr, dma_wen, dma_addr, dma_wdata};

    always_comb begin
        gnt = '0;
        if (!reset) begin
            gnt[1] = dma_req && (!cpu_req || (starve_cnt == STARVE_LIM));
            gnt[0] = cpu_req && !(dma_req && (starve_cnt == STARVE_LIM));
        end
    end

    assign any_gnt  = |gnt;
    assign sel      = gnt[1] ? port_req[1] : port_req[0];
    assign rd_grant = any_gnt && !sel.wr;

    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        if (any_gnt) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = sel.wr ? sel.wen : 4'b0000;
            data_sram_addr  = {sel.addr[31:2], 2'b00};
            data_sram_wdata = sel.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            if (dma_req && !gnt[1])
                starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
            else
                starve_cnt <= '0;
            rd_pend  <= rd_grant;
            rd_owner <= rd_grant && gnt[1];
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
        dsram_arb_rsp #(.PORT_ID(p)) u_rsp (
            .rd_pend    (rd_pend),
            .rd_owner   (rd_owner),
            .reset      (reset),
            .sram_rdata (data_sram_rdata),
            .rvalid     (rvalid[p]),
            .rdata      (rdata[p])
        );
    end

    assign cpu_gnt    = gnt[0];
    assign dma_gnt    = gnt[1];
    assign cpu_rvalid = rvalid[0];
    assign dma_rvalid = rvalid[1];
    assign cpu_rdata  = rdata[0];
    assign dma_rdata  = rdata[1];
endmodule

// File: tb/tb_dsram_arbiter.sv
// Bench for dsram_arbiter: behavioural SRAM, read-return scoreboard, per-scenario tasks.

module tb_dsram_arbiter;
    logic        clk = 0;
    logic        reset;
    logic        cpu_req, cpu_wr, dma_req, dma_wr;
    logic [3:0]  cpu_wen, dma_wen;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [31:0] data_sram_rdata = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic [31:0] mem [0:4095];

    dsram_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_wen(dma_wen), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // Behavioural single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (data_sram_en) begin
            if (data_sram_wen == 4'b0000)
                data_sram_rdata <= mem[data_sram_addr[13:2]];
            else
                for (int b = 0; b < 4; b++)
                    if (data_sram_wen[b])
                        mem[data_sram_addr[13:2]][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
    end

    // Return monitor: every cycle, either the due scoreboard entry or silence on both ports.
    always @(negedge clk) begin
        checks++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            if (cpu_rvalid !== !mon_e.port || dma_rvalid !== mon_e.port ||
                (mon_e.port ? dma_rdata : cpu_rdata) !== mon_e.data ||
                (mon_e.port ? cpu_rdata : dma_rdata) !== 32'h0) begin
                failures++;
                $display("FAIL return cyc=%0d got cpu_rv=%b dma_rv=%b cpu_rd=%h dma_rd=%h exp port=%0d data=%h",
                         cyc, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, mon_e.port, mon_e.data);
            end
        end else if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 ||
                     cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin
            failures++;
            $display("FAIL idle_return cyc=%0d got cpu_rv=%b dma_rv=%b cpu_rd=%h dma_rd=%h exp all 0",
                     cyc, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit port, input logic [31:0] d);
        sb.push_back('{port: port, data: d, due: cyc + 1});
    endtask

    task automatic idle();
        cpu_req = 0; dma_req = 0; cpu_wr = 0; dma_wr = 0; cpu_wen = 0; dma_wen = 0;
        step();
    endtask

    task automatic test_reset();
        reset = 1; cpu_req = 1; dma_req = 1; cpu_wr = 0; dma_wr = 0;
        cpu_addr = 32'h10; dma_addr = 32'h14;
        step(); step();
        #2;
        checks++;
        if ({cpu_gnt, dma_gnt, data_sram_en, data_sram_wen} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b%b en=%b wen=%b exp 0", cpu_gnt, dma_gnt, data_sram_en, data_sram_wen);
        end
        checks++;
        if (dut.starve_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_starve got=%0d exp=0", dut.starve_cnt);
        end
        reset = 0;
        idle();
    endtask

    task automatic test_cpu_load();
        cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h1003;
        #2;
        checks++;
        if (cpu_gnt !== 1 || dma_gnt !== 0 || data_sram_en !== 1 ||
            data_sram_addr !== 32'h1000 || data_sram_wen !== 4'b0000) begin
            failures++;
            $display("FAIL cpu_load_drive got gnt=%b%b en=%b addr=%h wen=%b exp 10 1 00001000 0000",
                     cpu_gnt, dma_gnt, data_sram_en, data_sram_addr, data_sram_wen);
        end
        push_exp(0, 32'hA5A5_1234);
        step();
        idle();
    endtask

    task automatic test_cpu_store();
        cpu_req = 1; cpu_wr = 1; cpu_wen = 4'b0011; cpu_addr = 32'h20; cpu_wdata = 32'h0000_BEEF;
        #2;
        checks++;
        if (cpu_gnt !== 1 || data_sram_en !== 1 || data_sram_wen !== 4'b0011 ||
            data_sram_wdata !== 32'h0000_BEEF || data_sram_addr !== 32'h20) begin
            failures++;
            $display("FAIL cpu_store_drive got gnt=%b en=%b wen=%b wdata=%h addr=%h exp 1 1 0011 0000beef 00000020",
                     cpu_gnt, data_sram_en, data_sram_wen, data_sram_wdata, data_sram_addr);
        end
        step();
        // zero-lane store: consumes a grant, writes nothing, returns nothing
        cpu_wen = 4'b0000; cpu_addr = 32'h24; cpu_wdata = 32'hFFFF_FFFF;
        #2;
        checks++;
        if (cpu_gnt !== 1 || data_sram_en !== 1 || data_sram_wen !== 4'b0000) begin
            failures++;
            $display("FAIL store_noop got gnt=%b en=%b wen=%b exp 1 1 0000", cpu_gnt, data_sram_en, data_sram_wen);
        end
        step();
        cpu_wr = 0; cpu_addr = 32'h20;
        push_exp(0, 32'hC0DE_BEEF);
        step();
        idle();
    endtask

    task automatic test_starve();
        logic [3:0] exp_cnt [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        cpu_req = 1; dma_req = 1; cpu_wr = 0; dma_wr = 0; dma_addr = 32'h200;
        for (int k = 0; k < 6; k++) begin
            cpu_addr = 32'h100 + 32'(4 * k);
            #2;
            checks++;
            if (cpu_gnt !== (k != 4) || dma_gnt !== (k == 4) || dut.starve_cnt !== exp_cnt[k]) begin
                failures++;
                $display("FAIL starve k=%0d got gnt=%b%b cnt=%0d exp gnt=%b%b cnt=%0d",
                         k, cpu_gnt, dma_gnt, dut.starve_cnt, k != 4, k == 4, exp_cnt[k]);
            end
            if (k == 4) push_exp(1, pat(128));
            else        push_exp(0, pat(64 + k));
            step();
        end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            cpu_wr = 0; dma_wr = 0;
            cpu_req = (k % 2 == 0); dma_req = (k % 2 == 1);
            cpu_addr = 32'h300 + 32'(4 * k); dma_addr = 32'h380 + 32'(4 * k);
            #2;
            checks++;
            if (cpu_gnt !== (k % 2 == 0) || dma_gnt !== (k % 2 == 1)) begin
                failures++;
                $display("FAIL alt_gnt k=%0d got gnt=%b%b exp=%b%b", k, cpu_gnt, dma_gnt, k % 2 == 0, k % 2 == 1);
            end
            if (k % 2 == 0) push_exp(0, pat(192 + k));
            else            push_exp(1, pat(224 + k));
            step();
        end
        idle();
    endtask

    task automatic test_reset_mid_read();
        dma_req = 1; dma_wr = 0; dma_addr = 32'h2A0;
        #2;
        checks++;
        if (dma_gnt !== 1) begin
            failures++;
            $display("FAIL mid_read_gnt got=%b exp=1", dma_gnt);
        end
        step();
        reset = 1; dma_req = 0;
        for (int k = 0; k < 2; k++) begin
            #2;
            checks++;
            if (dma_rvalid !== 0 || dma_rdata !== 0 || data_sram_en !== 0 || cpu_gnt !== 0 || dma_gnt !== 0) begin
                failures++;
                $display("FAIL mid_read_reset k=%0d got rv=%b rd=%h en=%b gnt=%b%b exp all 0",
                         k, dma_rvalid, dma_rdata, data_sram_en, cpu_gnt, dma_gnt);
            end
            step();
        end
        reset = 0;
        #2;
        checks++;
        if (dut.starve_cnt !== 0) begin
            failures++;
            $display("FAIL mid_read_starve got=%0d exp=0", dut.starve_cnt);
        end
        idle();
    endtask

    task automatic test_starve_restart();
        logic [3:0] exp_cnt [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        cpu_req = 1; cpu_wr = 0; dma_wr = 0; dma_addr = 32'h240;
        for (int k = 0; k < 9; k++) begin
            dma_req = (k != 3);
            cpu_addr = 32'h140 + 32'(4 * k);
            #2;
            checks++;
            if (dma_gnt !== (k == 8) || cpu_gnt !== (k != 8) || dut.starve_cnt !== exp_cnt[k]) begin
                failures++;
                $display("FAIL restart k=%0d got gnt=%b%b cnt=%0d exp gnt=%b%b cnt=%0d",
                         k, cpu_gnt, dma_gnt, dut.starve_cnt, k != 8, k == 8, exp_cnt[k]);
            end
            if (k == 8) push_exp(1, pat(144));
            else        push_exp(0, pat(80 + k));
            step();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = pat(i);
        mem[12'h400] = 32'hA5A5_1234;
        reset = 1;
        cpu_req = 0; cpu_wr = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_wr = 0; dma_wen = 0; dma_addr = 0; dma_wdata = 0;
        test_reset();
        test_cpu_load();
        test_cpu_store();
        test_starve();
        test_back_to_back();
        test_reset_mid_read();
        test_starve_restart();
        step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
